// File: rtl/lsu_ctrl.sv
// Load/store sequencer between EX/MEM and a single-ported data-memory bus.
// Runs one req/ack access per load or store and stalls the pipeline while the
// access is in flight. Builds byte enables, moves store data onto its byte
// lanes and right-justifies load data into mrd. Aborts with bus_err if no ack
// arrives within TimeoutCycles cycles.
// Build option LSU_MISALIGN_TRAP_EN: when defined, a misaligned access issues
// no bus cycle and pulses misalign instead. When undefined, the low address
// bits are masked to the access size and misalign is tied low.
`timescale 1ns/1ps

module lsu_ctrl #(
    parameter int WordSize      = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic [1:0]          size,
    input  logic [WordSize-1:0] addr,
    input  logic [WordSize-1:0] wdata,
    output logic                bus_req,
    output logic                bus_we,
    output logic [WordSize-1:0] bus_addr,
    output logic [3:0]          bus_be,
    output logic [WordSize-1:0] bus_wdata,
    input  logic                bus_ack,
    input  logic [WordSize-1:0] bus_rdata,
    output logic                stall,
    output logic [WordSize-1:0] mrd,
    output logic                misalign,
    output logic                bus_err
);

    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CntW-1:0] cnt;
    logic [1:0]      off_q;
    logic [1:0]      size_q;

    logic            req_any;
    logic            is_half;
    logic            is_word;
    logic [1:0]      off;
    logic            start;

    // Byte enables for an access of the given size at the given lane offset.
    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'd0:    return 4'b0001 << lo;
            2'd1:    return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    // Move right-justified store data up to its byte lanes.
    function automatic logic [WordSize-1:0] lane_align(input logic [WordSize-1:0] d,
                                                       input logic [1:0] lo);
        return d << {lo, 3'b000};
    endfunction

    // Pull the addressed lane(s) down to bit 0 and clear everything above the size.
    function automatic logic [WordSize-1:0] lane_extract(input logic [WordSize-1:0] d,
                                                         input logic [1:0] sz,
                                                         input logic [1:0] lo);
        logic [WordSize-1:0] t;
        t = d >> {lo, 3'b000};
        case (sz)
            2'd0:    return {{(WordSize-8){1'b0}}, t[7:0]};
            2'd1:    return {{(WordSize-16){1'b0}}, t[15:0]};
            default: return t;
        endcase
    endfunction

    assign req_any = mem_rd | mem_wr;
    assign is_half = (size == 2'd1);
    assign is_word = size[1];
    // Lane offset with the bits below the access size forced to zero; for an
    // aligned access this is just addr[1:0].
    assign off     = is_word ? 2'b00 : (is_half ? {addr[1], 1'b0} : addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misal;
    assign misal = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
    assign start = req_any & ~misal;
`else
    assign start = req_any;
`endif

    // Freeze the pipeline from the presenting cycle through the last REQ cycle;
    // reset releases it immediately.
    assign stall = rstn & (((state == IDLE) & start) | (state == REQ));

    // Access sequencer: launch in IDLE, wait for ack or timeout in REQ, one DONE cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            off_q     <= 2'b00;
            size_q    <= 2'b00;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= '0;
            mrd       <= '0;
            bus_err   <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bus_addr  <= {addr[WordSize-1:2], 2'b00};
                        bus_be    <= lane_be(size, off);
                        bus_wdata <= lane_align(wdata, off);
                        bus_we    <= mem_wr;
                        bus_req   <= 1'b1;
                        off_q     <= off;
                        size_q    <= size;
                        cnt       <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        if (!bus_we) begin
                            mrd <= lane_extract(bus_rdata, size_q, off_q);
                        end
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end else if (cnt == CntLast) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Flag a misaligned request seen in IDLE; it never reaches the bus.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            misalign <= 1'b0;
        end else begin
            misalign <= (state == IDLE) & req_any & misal;
        end
    end
`else
    assign misalign = 1'b0;
`endif

endmodule
